dma_copy: RTL and testbench

//  Word-granular memory-to-memory copy engine; the SoC's second bus initiator (host port 1).

---
 rtl/dma_copy_pkg.sv | 35 +++
 rtl/dma_copy_regs.sv | 121 ++++++++++++
 rtl/dma_copy.sv | 148 ++++++++++++++
 tb/tb_dma_copy.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_copy_pkg.sv
// Shared constants for the word-granular DMA copy engine: bus placement,
// register offsets, control/status bit positions and FSM state encodings.
// No logic lives here; everything is consumed by dma_copy and dma_copy_regs.
package dma_copy_pkg;

    // Default datapath widths
    localparam int XLEN_DEF      = 32;
    localparam int LEN_WIDTH_DEF = 16;

    // Bus placement: initiator port index and responder window
    localparam int          HOST_DMA_PORT = 1;
    localparam logic [31:0] DMA_BASE      = 32'h0300_0000;
    localparam logic [31:0] DMA_MASK      = 32'hFFFF_0000;

    // Register offsets within the responder window (addr[4:0])
    localparam logic [4:0] OFF_SRC    = 5'h00;
    localparam logic [4:0] OFF_DST    = 5'h04;
    localparam logic [4:0] OFF_LEN    = 5'h08;
    localparam logic [4:0] OFF_CTRL   = 5'h0C;
    localparam logic [4:0] OFF_STATUS = 5'h10;

    // Bit positions
    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STAT_BUSY_BIT   = 0;
    localparam int STAT_DONE_BIT   = 1;

    // Copy FSM state encodings
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_WR_REQ  = 3'd3;
    localparam logic [2:0] ST_FIN     = 3'd4;

endpackage

// File: rtl/dma_copy_regs.sv
// Config register file for the DMA engine: decode, SRC/DST/LEN/CTRL/STATUS, read mux.
// Latency: read data appears on data_o one cycle after a read strobe; writes take effect next edge.
// Backpressure: none, config port is zero-wait; SRC/DST/LEN/START writes are dropped while busy.
module dma_copy_regs
    import dma_copy_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [XLEN-1:0]      addr_i,
    input  logic [XLEN-1:0]      data_i,
    output logic [XLEN-1:0]      data_o,
    input  logic                 busy_i,
    input  logic                 fin_i,
    output logic                 start_o,
    output logic [XLEN-1:0]      src_o,
    output logic [XLEN-1:0]      dst_o,
    output logic [LEN_WIDTH-1:0] len_o,
    output logic                 irq_o
);

    logic [4:0]           off;
    logic                 wr_en;
    logic                 rd_en;
    logic                 unused_addr_bits;

    logic [XLEN-1:0]      src_q, src_d;
    logic [XLEN-1:0]      dst_q, dst_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic                 irq_en_q, irq_en_d;
    logic                 done_q, done_d;
    logic [XLEN-1:0]      rdata_q, rdata_d;

    // Device selection happens in the bus fabric; only the low offset bits matter here.
    assign off              = addr_i[4:0];
    assign unused_addr_bits = &{1'b0, addr_i[XLEN-1:5]};
    assign wr_en            = req_i & we_i;
    assign rd_en            = req_i & ~we_i;

    // START is a single-cycle pulse, only accepted while the engine is idle.
    assign start_o = wr_en & (off == OFF_CTRL) & data_i[CTRL_START_BIT] & ~busy_i;

    // Next-state for the register file and the registered read mux.
    always_comb begin
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        rdata_d  = '0;

        // Transfer parameters are frozen while a copy is in flight.
        if (wr_en && !busy_i) begin
            case (off)
                OFF_SRC: src_d = {data_i[XLEN-1:2], 2'b00};
                OFF_DST: dst_d = {data_i[XLEN-1:2], 2'b00};
                OFF_LEN: len_d = data_i[LEN_WIDTH-1:0];
                default: ;
            endcase
        end

        if (wr_en && (off == OFF_CTRL)) begin
            irq_en_d = data_i[CTRL_IRQ_EN_BIT];
        end

        // DONE priority, lowest to highest: software clear, new start, FIN set.
        if (wr_en && (off == OFF_STATUS) && data_i[STAT_DONE_BIT]) begin
            done_d = 1'b0;
        end
        if (start_o) begin
            done_d = 1'b0;
        end
        if (fin_i) begin
            done_d = 1'b1;
        end

        if (rd_en) begin
            case (off)
                OFF_SRC:    rdata_d = src_q;
                OFF_DST:    rdata_d = dst_q;
                OFF_LEN:    rdata_d = {{(XLEN-LEN_WIDTH){1'b0}}, len_q};
                OFF_CTRL:   rdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
                OFF_STATUS: begin
                    rdata_d[STAT_BUSY_BIT] = busy_i;
                    rdata_d[STAT_DONE_BIT] = done_q;
                end
                default:    rdata_d = '0;
            endcase
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
        end
    end

    assign data_o = rdata_q;
    assign src_o  = src_q;
    assign dst_o  = dst_q;
    assign len_o  = len_q;
    assign irq_o  = done_q & irq_en_q;

endmodule

// File: rtl/dma_copy.sv
// Memory-to-memory word copy engine: config responder plus a read-then-write bus initiator.
// Latency: 3 cycles per word with immediate grant; N words complete 3N+2 cycles after the START write.
// Backpressure: host_req_o and all host_* outputs hold steady until host_gnt_i; no internal buffering.
module dma_copy
    import dma_copy_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] data_o,
    output logic            host_req_o,
    input  logic            host_gnt_i,
    output logic [XLEN-1:0] host_addr_o,
    output logic            host_we_o,
    output logic [XLEN-1:0] host_wdata_o,
    input  logic [XLEN-1:0] host_rdata_i,
    output logic            irq_o
);

    localparam logic [XLEN-1:0]      WORD_BYTES = XLEN'(4);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE    = LEN_WIDTH'(1);

    logic                 start;
    logic                 busy;
    logic                 fin;
    logic [XLEN-1:0]      cfg_src;
    logic [XLEN-1:0]      cfg_dst;
    logic [LEN_WIDTH-1:0] cfg_len;

    logic [2:0]           state_q, state_d;
    logic [XLEN-1:0]      cur_src_q, cur_src_d;
    logic [XLEN-1:0]      cur_dst_q, cur_dst_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic [XLEN-1:0]      buf_q, buf_d;

    // BUSY covers every non-idle state including FIN, so it drops on the same edge DONE rises.
    assign busy = (state_q != ST_IDLE);
    assign fin  = (state_q == ST_FIN);

    dma_copy_regs #(
        .XLEN      (XLEN),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_regs (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .busy_i  (busy),
        .fin_i   (fin),
        .start_o (start),
        .src_o   (cfg_src),
        .dst_o   (cfg_dst),
        .len_o   (cfg_len),
        .irq_o   (irq_o)
    );

    // Copy FSM: latch the job on START, then alternate read and write one word at a time.
    always_comb begin
        state_d     = state_q;
        cur_src_d   = cur_src_q;
        cur_dst_d   = cur_dst_q;
        remaining_d = remaining_q;
        buf_d       = buf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_src_d   = cfg_src;
                    cur_dst_d   = cfg_dst;
                    remaining_d = cfg_len;
                    state_d     = (cfg_len == '0) ? ST_FIN : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (host_gnt_i) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                buf_d   = host_rdata_i;
                state_d = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                if (host_gnt_i) begin
                    // Address arithmetic wraps modulo 2^XLEN by design.
                    cur_src_d   = cur_src_q + WORD_BYTES;
                    cur_dst_d   = cur_dst_q + WORD_BYTES;
                    remaining_d = remaining_q - LEN_ONE;
                    state_d     = (remaining_q == LEN_ONE) ? ST_FIN : ST_RD_REQ;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and datapath state with synchronous reset; reset aborts any copy in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cur_src_q   <= '0;
            cur_dst_q   <= '0;
            remaining_q <= '0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            cur_src_q   <= cur_src_d;
            cur_dst_q   <= cur_dst_d;
            remaining_q <= remaining_d;
            buf_q       <= buf_d;
        end
    end

    // Initiator outputs decode straight from registered state, so they cannot move while stalled.
    always_comb begin
        host_req_o   = 1'b0;
        host_we_o    = 1'b0;
        host_addr_o  = '0;
        host_wdata_o = '0;
        case (state_q)
            ST_RD_REQ: begin
                host_req_o  = 1'b1;
                host_addr_o = cur_src_q;
            end
            ST_WR_REQ: begin
                host_req_o   = 1'b1;
                host_we_o    = 1'b1;
                host_addr_o  = cur_dst_q;
                host_wdata_o = buf_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dma_copy.sv
// Self-checking bench for dma_copy: register table, then directed copy sequences
// against a 4 KB word memory model (addresses alias on bits [11:2]).
module tb_dma_copy;

    localparam logic [31:0] A_SRC = 32'h00, A_DST = 32'h04, A_LEN = 32'h08;
    localparam logic [31:0] A_CTRL = 32'h0C, A_STAT = 32'h10;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        host_req_o;
    logic        host_gnt_i;
    logic [31:0] host_addr_o;
    logic        host_we_o;
    logic [31:0] host_wdata_o;
    logic [31:0] host_rdata_i = '0;
    logic        irq_o;

    int checks = 0;
    int fails  = 0;

    logic [31:0] mem [0:1023];
    logic        stall_mode = 1'b0;
    int          stall_cnt = 0;
    int          stall_cycles = 0;
    int          req_cycles = 0;
    logic [31:0] rd_log[$];

    logic        pend = 1'b0;
    logic [31:0] s_addr, s_wdata;
    logic        s_we;

    always #5 clk = ~clk;

    assign host_gnt_i = !stall_mode || (stall_cnt == 5);

    dma_copy dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .data_i       (data_i),
        .data_o       (data_o),
        .host_req_o   (host_req_o),
        .host_gnt_i   (host_gnt_i),
        .host_addr_o  (host_addr_o),
        .host_we_o    (host_we_o),
        .host_wdata_o (host_wdata_o),
        .host_rdata_i (host_rdata_i),
        .irq_o        (irq_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Memory model: one-cycle read latency, optional 5-cycle stall per access.
    always @(posedge clk) begin
        if (host_req_o) req_cycles++;
        if (host_req_o && !host_gnt_i) begin
            stall_cnt <= stall_cnt + 1;
            stall_cycles++;
        end else begin
            stall_cnt <= 0;
        end
        if (host_req_o && host_gnt_i) begin
            if (host_we_o) begin
                mem[host_addr_o[11:2]] = host_wdata_o;
            end else begin
                host_rdata_i <= mem[host_addr_o[11:2]];
                rd_log.push_back(host_addr_o);
            end
        end
    end

    // While a request is stalled, the initiator outputs must not move.
    always @(negedge clk) begin
        if (pend) begin
            chk1("stall_req_held", host_req_o, 1'b1);
            chk("stall_addr_held", host_addr_o, s_addr);
            chk1("stall_we_held", host_we_o, s_we);
            chk("stall_wdata_held", host_wdata_o, s_wdata);
        end
        pend    = stall_mode && host_req_o && !host_gnt_i;
        s_addr  = host_addr_o;
        s_we    = host_we_o;
        s_wdata = host_wdata_o;
    end

    task automatic cfg_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d;
        @(negedge clk);
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;
    endtask

    task automatic cfg_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; addr_i = a;
        @(negedge clk);
        req_i = 1'b0; addr_i = '0;
        d = data_o;
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        cfg_read(a, v);
        chk(name, v, exp);
    endtask

    // Writes START|IRQ_EN and counts cycles, the write cycle included, until irq_o rises.
    task automatic start_timed(output int cycles);
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; addr_i = A_CTRL; data_i = 32'h3;
        @(negedge clk);
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;
        cycles = 1;
        while (!irq_o && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
        chk1("irq_within_bound", irq_o, 1'b1);
    endtask

    task automatic wait_irq(input string name);
        int n = 0;
        while (!irq_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk1(name, irq_o, 1'b1);
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int cyc;
        int n;
        logic [31:0] v;

        vecs[0] = '{"src_align",    32'h0000_0000, 32'h0000_0103, 32'h0000_0100};
        vecs[1] = '{"dst_align",    32'h0000_0004, 32'hABCD_0007, 32'hABCD_0004};
        vecs[2] = '{"len_trunc",    32'h0000_0008, 32'h0001_2345, 32'h0000_2345};
        vecs[3] = '{"ctrl_irqen",   32'h0000_000C, 32'h0000_0002, 32'h0000_0002};
        vecs[4] = '{"ctrl_mask",    32'h0000_000C, 32'hFFFF_FFFE, 32'h0000_0002};
        vecs[5] = '{"status_ro",    32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[6] = '{"off14_zero",   32'h0000_0014, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[7] = '{"off1c_zero",   32'h0000_001C, 32'h0000_1234, 32'h0000_0000};
        vecs[8] = '{"src_based",    32'h0300_0000, 32'h3000_0201, 32'h3000_0200};
        vecs[9] = '{"ctrl_clear",   32'h0300_000C, 32'h0000_0000, 32'h0000_0000};

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        chk1("rst_host_req", host_req_o, 1'b0);
        chk1("rst_host_we", host_we_o, 1'b0);
        chk("rst_host_addr", host_addr_o, 32'h0);
        chk("rst_host_wdata", host_wdata_o, 32'h0);
        chk("rst_data_o", data_o, 32'h0);
        chk1("rst_irq", irq_o, 1'b0);
        rst_i = 1'b0;
        read_chk("rst_src", A_SRC, 32'h0);
        read_chk("rst_dst", A_DST, 32'h0);
        read_chk("rst_len", A_LEN, 32'h0);
        read_chk("rst_ctrl", A_CTRL, 32'h0);
        read_chk("rst_status", A_STAT, 32'h0);

        // Register table: write, read back, then data_o must return to 0
        for (int i = 0; i < 10; i++) begin
            cfg_write(vecs[i].addr, vecs[i].wdata);
            cfg_read(vecs[i].addr, v);
            chk(vecs[i].name, v, vecs[i].exp);
            @(negedge clk);
            chk("data_o_idle", data_o, 32'h0);
        end

        // T1: 4-word copy with immediate grant
        mem[10'h40] = 32'hA0A0_0001; mem[10'h41] = 32'hB0B0_0002;
        mem[10'h42] = 32'hC0C0_0003; mem[10'h43] = 32'hD0D0_0004;
        cfg_write(A_SRC, 32'h100);
        cfg_write(A_DST, 32'h800);
        cfg_write(A_LEN, 32'h4);
        start_timed(cyc);
        chk_int("t1_cycles", cyc, 14);
        chk("t1_w0", mem[10'h200], 32'hA0A0_0001);
        chk("t1_w1", mem[10'h201], 32'hB0B0_0002);
        chk("t1_w2", mem[10'h202], 32'hC0C0_0003);
        chk("t1_w3", mem[10'h203], 32'hD0D0_0004);
        read_chk("t1_status", A_STAT, 32'h2);
        read_chk("t1_src_kept", A_SRC, 32'h100);
        read_chk("t1_len_kept", A_LEN, 32'h4);

        // T2: zero-length transfer
        cfg_write(A_STAT, 32'h2);
        chk1("t2_irq_cleared", irq_o, 1'b0);
        cfg_write(A_LEN, 32'h0);
        req_cycles = 0;
        start_timed(cyc);
        chk_int("t2_cycles", cyc, 2);
        chk_int("t2_no_req", req_cycles, 0);
        cfg_write(A_CTRL, 32'h0);
        chk1("t2_irq_masked", irq_o, 1'b0);
        read_chk("t2_done_kept", A_STAT, 32'h2);
        cfg_write(A_STAT, 32'h2);

        // T3: every access stalled 5 cycles
        mem[10'h50] = 32'h1111_EEEE; mem[10'h51] = 32'h2222_FFFF;
        cfg_write(A_SRC, 32'h140);
        cfg_write(A_DST, 32'h840);
        cfg_write(A_LEN, 32'h2);
        stall_mode = 1'b1;
        stall_cycles = 0;
        start_timed(cyc);
        stall_mode = 1'b0;
        chk_int("t3_cycles", cyc, 28);
        chk_int("t3_stall_cycles", stall_cycles, 20);
        chk("t3_w0", mem[10'h210], 32'h1111_EEEE);
        chk("t3_w1", mem[10'h211], 32'h2222_FFFF);
        cfg_write(A_STAT, 32'h2);

        // T4: SRC/LEN/START writes while busy are dropped
        mem[10'h60] = 32'h6000_0000; mem[10'h61] = 32'h6000_0001; mem[10'h62] = 32'h6000_0002;
        mem[10'h80] = 32'h8BAD_0000; mem[10'h81] = 32'h8BAD_0001; mem[10'h82] = 32'h8BAD_0002;
        cfg_write(A_SRC, 32'h180);
        cfg_write(A_DST, 32'h880);
        cfg_write(A_LEN, 32'h3);
        cfg_write(A_CTRL, 32'h3);
        cfg_write(A_SRC, 32'h200);
        cfg_write(A_LEN, 32'h1);
        cfg_write(A_CTRL, 32'h3);
        wait_irq("t4_irq");
        chk("t4_w0", mem[10'h220], 32'h6000_0000);
        chk("t4_w1", mem[10'h221], 32'h6000_0001);
        chk("t4_w2", mem[10'h222], 32'h6000_0002);
        read_chk("t4_src_kept", A_SRC, 32'h180);
        read_chk("t4_len_kept", A_LEN, 32'h3);
        cfg_write(A_STAT, 32'h2);
        read_chk("t4_status_clr", A_STAT, 32'h0);
        chk1("t4_irq_clr", irq_o, 1'b0);
        req_cycles = 0;
        repeat (20) @(negedge clk);
        chk_int("t4_no_restart", req_cycles, 0);

        // T5: source address wraps past 0xFFFFFFFC
        mem[10'h3FF] = 32'h5555_0001; mem[10'h000] = 32'h5555_0002;
        cfg_write(A_SRC, 32'hFFFF_FFFC);
        cfg_write(A_DST, 32'h900);
        cfg_write(A_LEN, 32'h2);
        rd_log.delete();
        start_timed(cyc);
        chk_int("t5_cycles", cyc, 8);
        chk_int("t5_reads", rd_log.size(), 2);
        if (rd_log.size() >= 2) begin
            chk("t5_rd0_addr", rd_log[0], 32'hFFFF_FFFC);
            chk("t5_rd1_addr", rd_log[1], 32'h0000_0000);
        end
        chk("t5_w0", mem[10'h240], 32'h5555_0001);
        chk("t5_w1", mem[10'h241], 32'h5555_0002);
        cfg_write(A_STAT, 32'h2);

        // T6: reset during WR_REQ aborts; engine restarts cleanly
        cfg_write(A_SRC, 32'h100);
        cfg_write(A_DST, 32'hA00);
        cfg_write(A_LEN, 32'h3);
        cfg_write(A_CTRL, 32'h3);
        n = 0;
        while (!(host_req_o && host_we_o) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk1("t6_reached_wr_req", host_req_o && host_we_o, 1'b1);
        rst_i = 1'b1;
        @(negedge clk);
        chk1("t6_req_dropped", host_req_o, 1'b0);
        chk1("t6_we_dropped", host_we_o, 1'b0);
        chk1("t6_irq", irq_o, 1'b0);
        rst_i = 1'b0;
        read_chk("t6_src", A_SRC, 32'h0);
        read_chk("t6_dst", A_DST, 32'h0);
        read_chk("t6_len", A_LEN, 32'h0);
        read_chk("t6_ctrl", A_CTRL, 32'h0);
        read_chk("t6_status", A_STAT, 32'h0);
        req_cycles = 0;
        repeat (5) @(negedge clk);
        chk_int("t6_idle_after_rst", req_cycles, 0);
        cfg_write(A_SRC, 32'h100);
        cfg_write(A_DST, 32'hB00);
        cfg_write(A_LEN, 32'h1);
        start_timed(cyc);
        chk_int("t6_restart_cycles", cyc, 5);
        chk("t6_restart_w0", mem[10'h2C0], 32'hA0A0_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Absolute time guard
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
